// File: rtl/morse_symbol_ctrl.sv
// Morse element capture: times key presses against a tick timebase, packs dots/dashes
// into a per-character pattern and emits one character record after the inter-character gap.
module morse_symbol_ctrl #(
  parameter int DASH_TICKS = 3,
  parameter int GAP_TICKS  = 7,
  parameter int MAX_ELEMS  = 5,
  parameter int CNT_W      = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       tick,
  input  logic       key,
  output logic       sym_valid,
  output logic [2:0] sym_len,
  output logic [4:0] sym_bits,
  output logic       sym_err,
  output logic [2:0] elem_cnt,
  output logic       busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRESS = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] EMIT  = 2'd3;

  localparam logic [CNT_W-1:0] DUR_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DASH_TH  = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] GAP_TH   = CNT_W'(GAP_TICKS);
  localparam logic [2:0]       ELEM_MAX = 3'(MAX_ELEMS);

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] dur, dur_n;
  logic [CNT_W-1:0] gap, gap_n;
  logic [2:0]       elem_n;
  logic [4:0]       pattern, pattern_n;
  logic             ovf, ovf_n;

  always_comb begin
    // NOTE: every signal gets a hold-value default before the case so no path infers a latch.
    state_n   = state;
    dur_n     = dur;
    gap_n     = gap;
    elem_n    = elem_cnt;
    pattern_n = pattern;
    ovf_n     = ovf;
    case (state)
      IDLE: begin
        if (key) begin
          state_n = PRESS;
          dur_n   = '0;
        end
      end
      PRESS: begin
        if (!key) begin
          // Release: a tick on this cycle is deliberately not added to dur.
          if (elem_cnt < ELEM_MAX) begin
            pattern_n[elem_cnt] = (dur >= DASH_TH);
            elem_n              = elem_cnt + 3'd1;
          end else begin
            ovf_n = 1'b1;
          end
          state_n = GAP;
          gap_n   = '0;
        end else if (tick && (dur != DUR_MAX)) begin
          dur_n = dur + CNT_ONE;
        end
      end
      GAP: begin
        // Key wins over a coincident tick so a late re-press extends the character.
        if (key) begin
          state_n = PRESS;
          dur_n   = '0;
        end else if (tick) begin
          gap_n = gap + CNT_ONE;
          if (gap_n >= GAP_TH) state_n = EMIT;
        end
      end
      EMIT: begin
        state_n   = IDLE;
        elem_n    = '0;
        pattern_n = '0;
        ovf_n     = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state     <= IDLE;
      dur       <= '0;
      gap       <= '0;
      elem_cnt  <= '0;
      pattern   <= '0;
      ovf       <= 1'b0;
      sym_valid <= 1'b0;
      sym_len   <= '0;
      sym_bits  <= '0;
      sym_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      dur       <= dur_n;
      gap       <= gap_n;
      elem_cnt  <= elem_n;
      pattern   <= pattern_n;
      ovf       <= ovf_n;
      // The record is latched from EMIT so it appears one cycle after gap completes.
      sym_valid <= (state == EMIT);
      sym_len   <= (state == EMIT) ? elem_cnt : 3'd0;
      sym_bits  <= (state == EMIT) ? pattern  : 5'd0;
      sym_err   <= (state == EMIT) ? ovf      : 1'b0;
      busy      <= (state_n != IDLE);
    end
  end

endmodule
